lsu_mem_responder: RTL and testbench

- Memory-side responder that serves word-level read/write requests from the load/store unit.
- Accepts one request at a time over a valid/ready handshake.
- Models a configurable access latency, applies byte-masked writes to an internal word array, and returns read data and an error flag over a valid/ready response channel.
- Returns full aligned words: the requester does the sub-word lane shifting and sign extension. This block never shifts data.

---
 rtl/lsu_mem_responder.sv | 204 ++++++++++++++++++++
 tb/tb_lsu_mem_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_responder.sv
// Word-level memory responder for the LSU: one request at a time, fixed or LFSR-driven
// access latency, byte-masked writes. Macro LSU_MEM_RANDOM_DELAY_EN selects LFSR-driven latency.
//
//   state  | meaning
//   IDLE   | ready for a request
//   WAIT   | counting down the access latency
//   RESP   | response held until the requester takes it
module lsu_mem_responder #(
    parameter int          ADDR_W  = 12,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          LATENCY = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_ren,
    input  logic        i_wen,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wmask,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_rdata,
    output logic        o_resp_err
);

    localparam int          DEPTH  = 2 ** ADDR_W;
    localparam logic [29:0] BASE_W = BASE[31:2];

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("lsu_mem_responder: LATENCY must be in 1..15");
    end
    if (ADDR_W < 1 || ADDR_W > 30) begin : g_bad_addr_w
        $error("lsu_mem_responder: ADDR_W must be in 1..30");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ren_q, ren_d;
    logic                wen_q, wen_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wmask_q, wmask_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                resp_err_q, resp_err_d;

    logic [31:0]         mem_q [DEPTH];

    logic [29:0]         word_off;
    logic                req_err;
    logic [ADDR_W-1:0]   req_idx;
    logic [3:0]          cnt_load;

    logic                acc_fire;
    logic                acc_from_in;
    logic                acc_ren;
    logic                acc_wen;
    logic                acc_err;
    logic [ADDR_W-1:0]   acc_idx;
    logic [31:0]         acc_wdata;
    logic [3:0]          acc_wmask;
    logic                mem_we;

    // Unsigned range check on the full address; the index is only meaningful when it passes.
    assign word_off = i_addr[31:2] - BASE_W;
    assign req_err  = (i_addr < BASE) || ((word_off >> ADDR_W) != '0);
    assign req_idx  = word_off[ADDR_W-1:0];

`ifdef LSU_MEM_RANDOM_DELAY_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign cnt_load = {1'b0, lfsr_q[2:0]};

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign cnt_load = 4'(LATENCY - 1);
`endif

    // With zero countdown the access happens on the accepting edge, so it must use the live inputs.
    assign acc_from_in = (state_q == S_IDLE);
    assign acc_ren     = acc_from_in ? i_ren     : ren_q;
    assign acc_wen     = acc_from_in ? i_wen     : wen_q;
    assign acc_err     = acc_from_in ? req_err   : err_q;
    assign acc_idx     = acc_from_in ? req_idx   : idx_q;
    assign acc_wdata   = acc_from_in ? i_wdata   : wdata_q;
    assign acc_wmask   = acc_from_in ? i_wmask   : wmask_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ren_d      = ren_q;
        wen_d      = wen_q;
        err_d      = err_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        rdata_d    = rdata_q;
        resp_err_d = resp_err_q;
        acc_fire   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    ren_d   = i_ren;
                    wen_d   = i_wen;
                    err_d   = req_err;
                    idx_d   = req_idx;
                    wdata_d = i_wdata;
                    wmask_d = i_wmask;
                    cnt_d   = cnt_load;
                    if (cnt_load == 4'd0) begin
                        acc_fire = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        state_d  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d    = 4'd0;
                    acc_fire = 1'b1;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (i_resp_ready) begin
                    state_d    = S_IDLE;
                    rdata_d    = 32'd0;
                    resp_err_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (acc_fire) begin
            rdata_d    = (acc_ren && !acc_err) ? mem_q[acc_idx] : 32'd0;
            resp_err_d = acc_err;
        end
    end

    // A write landing on a reset edge is dropped along with the rest of the transaction.
    assign mem_we = i_reset && acc_fire && acc_wen && !acc_err;

    always_ff @(posedge i_clock) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (acc_wmask[k]) begin
                    mem_q[acc_idx][8*k +: 8] <= acc_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            wmask_q    <= 4'd0;
            rdata_q    <= 32'd0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ren_q      <= ren_d;
            wen_q      <= wen_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            rdata_q    <= rdata_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign o_req_ready  = i_reset && (state_q == S_IDLE);
    assign o_resp_valid = (state_q == S_RESP);
    assign o_rdata      = rdata_q;
    assign o_resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Self-checking bench for lsu_mem_responder (default build, fixed latency) against a
// word-array reference model with directed boundary cases and random traffic.
module tb_lsu_mem_responder;

    localparam int          ADDR_W  = 12;
    localparam logic [31:0] BASE    = 32'h8000_0000;
    localparam int          LATENCY = 2;
    localparam int          DEPTH   = 2 ** ADDR_W;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_ren;
    logic        i_wen;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_wmask;
    logic        o_resp_valid;
    logic        i_resp_ready;
    logic [31:0] o_rdata;
    logic        o_resp_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ref_mem [DEPTH];

    lsu_mem_responder #(
        .ADDR_W  (ADDR_W),
        .BASE    (BASE),
        .LATENCY (LATENCY)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_ren        (i_ren),
        .i_wen        (i_wen),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_wmask      (i_wmask),
        .o_resp_valid (o_resp_valid),
        .i_resp_ready (i_resp_ready),
        .o_rdata      (o_rdata),
        .o_resp_err   (o_resp_err)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        longint unsigned av = longint'(a);
        longint unsigned lo = longint'(BASE);
        longint unsigned hi = lo + 64'(4 * DEPTH);
        return (av >= lo) && (av < hi);
    endfunction

    function automatic int addr_idx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // One full transaction: request, latency measurement, optional stall in RESP, handshake.
    task automatic txn(input bit ren, input bit wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask,
                       input int hold, input bit poke);
        bit          ok;
        int          idx;
        int          lat;
        logic [31:0] exp_rdata;
        ok        = addr_ok(addr);
        idx       = ok ? addr_idx(addr) : 0;
        exp_rdata = (ok && ren) ? ref_mem[idx] : 32'd0;

        @(negedge i_clock);
        i_req_valid = 1'b1;
        i_ren       = ren;
        i_wen       = wen;
        i_addr      = addr;
        i_wdata     = wdata;
        i_wmask     = wmask;
        check("req_ready_idle", 32'(o_req_ready), 32'd1);

        @(negedge i_clock);
        i_req_valid = 1'b0;
        lat = 1;
        while (o_resp_valid !== 1'b1 && lat < 40) begin
            @(negedge i_clock);
            lat++;
        end
        if (o_resp_valid !== 1'b1) begin
            check("resp_timeout", 32'(o_resp_valid), 32'd1);
            return;
        end
        check("latency", 32'(lat), 32'(LATENCY));
        check("rdata", o_rdata, exp_rdata);
        check("resp_err", 32'(o_resp_err), 32'(!ok));

        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                i_req_valid = 1'b1;
                i_ren       = 1'b0;
                i_wen       = 1'b1;
                i_addr      = BASE + 32'h40;
                i_wdata     = $urandom;
                i_wmask     = 4'hF;
            end
            @(negedge i_clock);
            check("hold_valid", 32'(o_resp_valid), 32'd1);
            check("hold_rdata", o_rdata, exp_rdata);
            check("hold_err", 32'(o_resp_err), 32'(!ok));
            check("hold_req_ready", 32'(o_req_ready), 32'd0);
        end

        i_req_valid  = 1'b0;
        i_resp_ready = 1'b1;
        @(negedge i_clock);
        i_resp_ready = 1'b0;
        check("post_valid", 32'(o_resp_valid), 32'd0);
        check("post_req_ready", 32'(o_req_ready), 32'd1);
        check("post_rdata_clr", o_rdata, 32'd0);
        check("post_err_clr", 32'(o_resp_err), 32'd0);

        if (ok && wen) begin
            for (int k = 0; k < 4; k++) begin
                if (wmask[k]) ref_mem[idx][8*k +: 8] = wdata[8*k +: 8];
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        bit          r;
        bit          w;
        i_reset      = 1'b0;
        i_req_valid  = 1'b0;
        i_ren        = 1'b0;
        i_wen        = 1'b0;
        i_addr       = 32'd0;
        i_wdata      = 32'd0;
        i_wmask      = 4'd0;
        i_resp_ready = 1'b0;

        repeat (3) begin
            @(negedge i_clock);
            check("rst_req_ready", 32'(o_req_ready), 32'd0);
        end
        i_reset = 1'b1;
        @(negedge i_clock);
        check("rel_req_ready", 32'(o_req_ready), 32'd1);
        check("rel_resp_valid", 32'(o_resp_valid), 32'd0);
        check("rel_rdata", o_rdata, 32'd0);
        check("rel_err", 32'(o_resp_err), 32'd0);

        for (int i = 0; i < 32; i++) begin
            txn(1'b0, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF, 0, 1'b0);
        end
        txn(1'b0, 1'b1, BASE + 32'h3FFC, 32'hCAFE_F00D, 4'hF, 0, 1'b0);
        txn(1'b1, 1'b0, BASE + 32'h3FFC, 32'd0, 4'h0, 0, 1'b0);

        txn(1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
        txn(1'b1, 1'b0, 32'h8000_0010, 32'd0, 4'h0, 0, 1'b0);

        txn(1'b0, 1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 0, 1'b0);
        txn(1'b0, 1'b1, 32'h8000_0020, 32'h0000_5500, 4'b0010, 0, 1'b0);
        txn(1'b1, 1'b0, 32'h8000_0020, 32'd0, 4'h0, 0, 1'b0);
        check("mask_model", ref_mem[8], 32'h1122_5544);

        txn(1'b0, 1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 0, 1'b0);
        txn(1'b1, 1'b1, 32'h8000_0020, 32'hA5A5_0F0F, 4'b1001, 0, 1'b0);
        txn(1'b1, 1'b0, 32'h8000_0020, 32'd0, 4'h0, 0, 1'b0);
        txn(1'b0, 1'b0, 32'h8000_0020, 32'h1234_0000, 4'hF, 0, 1'b0);

        txn(1'b1, 1'b0, 32'h7FFF_FFFC, 32'd0, 4'h0, 0, 1'b0);
        txn(1'b1, 1'b0, 32'h8000_4000, 32'd0, 4'h0, 0, 1'b0);
        txn(1'b0, 1'b1, 32'h8000_4000, 32'h5555_AAAA, 4'hF, 0, 1'b0);
        txn(1'b0, 1'b1, 32'h7FFF_FFFC, 32'h6666_9999, 4'hF, 0, 1'b0);
        txn(1'b1, 1'b0, BASE, 32'd0, 4'h0, 0, 1'b0);
        txn(1'b1, 1'b0, BASE + 32'h3FFC, 32'd0, 4'h0, 0, 1'b0);

        txn(1'b1, 1'b0, 32'h8000_0010, 32'd0, 4'h0, 5, 1'b1);
        repeat (LATENCY + 2) begin
            @(negedge i_clock);
            check("no_stray_resp", 32'(o_resp_valid), 32'd0);
        end
        txn(1'b1, 1'b0, BASE + 32'h40, 32'd0, 4'h0, 0, 1'b0);

        @(negedge i_clock);
        i_req_valid = 1'b1;
        i_ren       = 1'b0;
        i_wen       = 1'b1;
        i_addr      = 32'h8000_0010;
        i_wdata     = 32'h1234_5678;
        i_wmask     = 4'hF;
        @(negedge i_clock);
        i_req_valid = 1'b0;
        i_reset     = 1'b0;
        check("midrst_req_ready", 32'(o_req_ready), 32'd0);
        @(negedge i_clock);
        check("midrst_valid", 32'(o_resp_valid), 32'd0);
        @(negedge i_clock);
        i_reset = 1'b1;
        repeat (4) begin
            @(negedge i_clock);
            check("midrst_no_resp", 32'(o_resp_valid), 32'd0);
        end
        txn(1'b1, 1'b0, 32'h8000_0010, 32'd0, 4'h0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                a = ($urandom_range(0, 1) == 0) ? (BASE - 32'(4 * $urandom_range(1, 64)))
                                                : (BASE + 32'h4000 + 32'(4 * $urandom_range(0, 64)));
            end else begin
                a = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
            end
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            txn(r, w, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
